// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the five-stage pipeline: drives register
// enables/flushes and the PC write enable, and keeps saturating stall/squash counters.
module pipeline_controller #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_jump,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_branch_taken,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic d_stall, load_use, squash;

    // Hazard terms use only registered pipeline fields and cache hit lines.
    assign d_stall  = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                      ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
    assign squash   = (state != ST_HALT) & exmem_branch_taken & ~d_stall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_RUN;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves a latch.
        state_next = state;
        case (state)
            ST_RUN:   if (d_stall) state_next = ST_DWAIT;
            ST_DWAIT: if (dhit)    state_next = ST_RUN;
            default:               state_next = ST_HALT;
        endcase
        if (state != ST_HALT && memwb_halt && !d_stall) state_next = ST_HALT;
    end

    // Rules are applied lowest priority first so each higher rule overrides only what it touches.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halt        = 1'b0;
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state == ST_HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halt     = 1'b1;
        end else begin
            if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            if (ifid_jump && ihit) ifid_flush = 1'b1;
            if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            if (exmem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                pc_en       = 1'b1;
            end
            if (d_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (state != ST_HALT && !pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (squash && squash_cnt != '1)
                squash_cnt <= squash_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller; a CNT_W=4 copy shares the
// stimulus to exercise counter saturation.
module tb_pipeline_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, ifid_uses_rt, ifid_jump, idex_dREN;
    logic       exmem_dREN, exmem_dWEN, exmem_branch_taken, memwb_halt;
    logic [4:0] ifid_rs, ifid_rt, idex_wsel;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [15:0] stall_cnt, squash_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt;
    logic [3:0]  s_stall_cnt, s_squash_cnt;

    int tests = 0;
    int fails = 0;

    // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, halt}
    logic [9:0] ctl;
    logic [9:0] exp_ctl;
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};

    always #5 CLK = ~CLK;

    pipeline_controller dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_jump(ifid_jump), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .exmem_branch_taken(exmem_branch_taken), .memwb_halt(memwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    pipeline_controller #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_jump(ifid_jump), .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .exmem_branch_taken(exmem_branch_taken), .memwb_halt(memwb_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halt(s_halt),
        .stall_cnt(s_stall_cnt), .squash_cnt(s_squash_cnt)
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ifid_uses_rt = 1'b0; ifid_jump = 1'b0; idex_dREN = 1'b0; idex_wsel = 5'd0;
        exmem_dREN = 1'b0; exmem_dWEN = 1'b0; exmem_branch_taken = 1'b0; memwb_halt = 1'b0;
    endtask

    // Advance one edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_ctl(input string name, input logic [9:0] expected);
        #1;
        tests++;
        if (ctl !== expected) begin
            fails++;
            $display("FAIL %s: ctl got %b expected %b", name, ctl, expected);
        end
    endtask

    task automatic test_stall(input string name, input logic [15:0] expected);
        tests++;
        if (stall_cnt !== expected) begin
            fails++;
            $display("FAIL %s: stall_cnt got %0d expected %0d", name, stall_cnt, expected);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; idle();
        test_ctl("reset_ctl_c0", 10'b0_0000_1111_0);
        tick();
        test_ctl("reset_ctl_c1", 10'b0_0000_1111_0);
        tick();
        test_stall("reset_stall_cnt", 16'd0);
        tests++;
        if (squash_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_squash_cnt: got %0d expected 0", squash_cnt);
        end
        RST = 1'b0;
        test_ctl("reset_release_run", 10'b1_1111_0000_0);
    endtask

    task automatic test_load_use();
        idle(); idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5;
        test_ctl("load_use_rs", 10'b0_0111_0100_0);
        tick();
        idex_dREN = 1'b0;
        test_ctl("load_use_cleared", 10'b1_1111_0000_0);
        test_stall("load_use_stall_cnt", 16'd1);
        idex_dREN = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0;
        test_ctl("load_use_r0", 10'b1_1111_0000_0);
        tick();
        idex_wsel = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b1;
        test_ctl("load_use_rt", 10'b0_0111_0100_0);
        tick();
        ifid_uses_rt = 1'b0;
        test_ctl("load_use_rt_unused", 10'b1_1111_0000_0);
        tick();
        test_stall("load_use_stall_cnt2", 16'd2);
    endtask

    task automatic test_dstall();
        idle(); exmem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            test_ctl($sformatf("dstall_cycle%0d", i), 10'b0_0001_0001_0);
            tick();
        end
        dhit = 1'b1;
        test_ctl("dstall_dhit", 10'b1_1111_0000_0);
        tick();
        idle();
        test_stall("dstall_stall_cnt", 16'd5);
    endtask

    task automatic test_branch();
        idle(); exmem_branch_taken = 1'b1; ihit = 1'b0;
        idex_dREN = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5;
        #1;
        tests++;
        if ({pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush} !== 5'b1_1110) begin
            fails++;
            $display("FAIL branch_priority: got %b expected 11110",
                     {pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush});
        end
        tick();
        idle();
        tests++;
        if (squash_cnt !== 16'd1) begin
            fails++;
            $display("FAIL branch_squash_cnt: got %0d expected 1", squash_cnt);
        end
        test_stall("branch_stall_cnt", 16'd5);
    endtask

    task automatic test_jump_istall();
        idle(); ifid_jump = 1'b1;
        test_ctl("jump_id", 10'b1_1111_1000_0);
        tick();
        idle(); ihit = 1'b0;
        test_ctl("istall", 10'b0_1111_1000_0);
        tick();
        idle();
        test_stall("istall_stall_cnt", 16'd6);
    endtask

    task automatic test_halt();
        idle(); exmem_dWEN = 1'b1; memwb_halt = 1'b1;
        test_ctl("halt_blocked_by_dstall", 10'b0_0001_0001_0);
        tick();
        dhit = 1'b1;
        test_ctl("halt_dhit_cycle", 10'b1_1111_0000_0);
        tick();
        for (int i = 0; i < 10; i++) begin
            {ihit, dhit, ifid_uses_rt, ifid_jump, idex_dREN, exmem_dREN,
             exmem_dWEN, exmem_branch_taken, memwb_halt} = 9'($urandom);
            ifid_rs = 5'($urandom); ifid_rt = 5'($urandom); idex_wsel = 5'($urandom);
            test_ctl($sformatf("halt_hold%0d", i), 10'b0_0000_0000_1);
            tick();
        end
        test_stall("halt_stall_frozen", 16'd7);
        tests++;
        if (squash_cnt !== 16'd1) begin
            fails++;
            $display("FAIL halt_squash_frozen: got %0d expected 1", squash_cnt);
        end
        idle(); RST = 1'b1;
        tick();
        RST = 1'b0;
        test_ctl("halt_reset_to_run", 10'b1_1111_0000_0);
        test_stall("halt_reset_stall_cnt", 16'd0);
    endtask

    task automatic test_saturation();
        idle(); ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        idle();
        tests++;
        if (s_stall_cnt !== 4'd15) begin
            fails++;
            $display("FAIL sat_stall_cnt4: got %0d expected 15", s_stall_cnt);
        end
        test_stall("sat_stall_cnt16", 16'd20);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dstall();
        test_branch();
        test_jump_istall();
        test_halt();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and sequencing controller for the five-stage pipeline. It drives the `enable` and `flush` controls of the four pipeline_register instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves instruction and data cache wait states, load-use hazards, taken-branch and jump squashes, and processor halt. It also keeps saturating stall and squash counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall_cnt and squash_cnt counters

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction cache returned valid instruction this cycle
- dhit  in  1  data cache completed the EX/MEM-stage access this cycle
- ifid_rs  in  5  rs field of the instruction in IF/ID
- ifid_rt  in  5  rt field of the instruction in IF/ID
- ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, BEQ/BNE, SW)
- ifid_jump  in  1  IF/ID instruction is J/JAL/JR
- idex_dREN  in  1  ID/EX instruction is a load
- idex_wsel  in  5  destination register of the ID/EX instruction
- exmem_dREN  in  1  EX/MEM instruction reads data memory
- exmem_dWEN  in  1  EX/MEM instruction writes data memory
- exmem_branch_taken  in  1  EX/MEM branch resolved taken
- memwb_halt  in  1  MEM/WB holds a HALT instruction
- pc_en  out  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  pipeline register clears (bubble)
- halt  out  1  processor halted (sticky)
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- squash_cnt  out  CNT_W  count of taken-branch squashes

## Operation
- Clock is CLK. Reset is RST, synchronous and active-high.
- States:
  - RUN: normal issue.
  - DWAIT: a data access is outstanding.
  - HALT: terminal until reset.
- Enable and flush outputs are combinational from the current state and inputs. A flush means "the register holds a bubble after the next edge". The downstream flush is level-clear, so every decode term must be glitch-free. Only registered pipeline signals and cache hit lines may feed it.
- Default in RUN/DWAIT: all en=1, all flush=0, pc_en=1.
- Priority, highest first. The first matching rule sets the affected outputs. Lower rules still apply to outputs that higher rules leave untouched, except where a rule says "all".
  1. HALT state: all en=0, all flush=0, pc_en=0, halt=1.
  2. D-stall, defined as (exmem_dREN|exmem_dWEN) & !dhit: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush=1.
  3. Taken branch (exmem_branch_taken): ifid_flush, idex_flush, exmem_flush = 1; pc_en=1.
  4. Load-use, defined as idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | (ifid_uses_rt & idex_wsel==ifid_rt)): pc_en=0, ifid_en=0, idex_flush=1.
  5. Jump in ID (ifid_jump & ihit): ifid_flush=1.
  6. I-stall (!ihit): pc_en=0, ifid_flush=1. Older stages advance.
- State transitions:
  - RUN→DWAIT on a D-stall.
  - DWAIT→RUN on dhit.
  - Any state→HALT when memwb_halt=1 and no D-stall. The MEM/WB register still loads in that cycle.
  - HALT→RUN only on RST.
- Counters:
  - stall_cnt increments in every non-HALT cycle with pc_en=0.
  - squash_cnt increments in every cycle where rule 3 fires.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- While RST=1, all flush=1, all en=0, pc_en=0, halt=0. At the reset edge: state=RUN, stall_cnt=0, squash_cnt=0.
- The first cycle after RST deasserts applies the RUN defaults.
- Load-use costs exactly 1 bubble. The cycle after, idex_dREN=0 from the flushed ID/EX, so the rule clears.
- A taken branch costs 3 squashed slots. The PC loads the target at the same edge.
- D-stall holds for N cycles of !dhit. The pipeline advances at the edge of the dhit cycle.
- Simultaneous events:
  - Branch plus load-use: the branch wins, and the dependent instruction is squashed anyway.
  - Branch plus !ihit: the branch flushes, and pc_en=1 redirects the fetch.
  - memwb_halt plus D-stall: the D-stall wins, and HALT is entered after dhit.
- RST asserted mid-DWAIT or in HALT: the state returns to RUN at that edge, and both counters clear.

## Test plan
- Reset: hold RST=1 for 2 cycles → all flush=1, all en=0, pc_en=0, counters=0. Release → all en=1, pc_en=1.
- Load-use: idex_dREN=1, idex_wsel=5, ifid_rs=5 → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle, stall_cnt=1. Repeat with wsel=0 → no stall.
- D-stall: exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles of frozen stages with memwb_flush=1, state DWAIT→RUN, stall_cnt=3.
- Branch: exmem_branch_taken=1 with !ihit and a load-use condition present → ifid/idex/exmem flush=1, pc_en=1, squash_cnt=1.
- Halt: memwb_halt=1 → next cycle halt=1, all en=0. Remains so for 10 cycles with random inputs. RST clears the state to RUN.
- Saturation: CNT_W=4, 20 consecutive I-stall cycles → stall_cnt stays at 15.
